// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//
// PS/2 device-to-host receiver with a first-word-fall-through byte FIFO.
// ps2_clk and ps2_data are synchronised into the clk domain. ps2_clk is then
// glitch-filtered, and each falling edge of the filtered clock samples one
// frame bit. A frame is: start(0), 8 data bits LSB first, odd parity, stop(1).
// Good bytes are pushed into the FIFO. Bad frames raise single-cycle error
// pulses.
//
// Parameters
//   FIFO_DEPTH   receive FIFO depth in bytes (power of 2, 2..256)
//   FILT_LEN     consecutive equal samples before filtered ps2_clk toggles
//   TIMEOUT_CYC  clk-cycle limit between PS/2 falling edges inside a frame
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   ps2_clk      asynchronous PS/2 clock from the device
//   ps2_data     asynchronous PS/2 data from the device
//   rx_en        receive enable; low aborts any partial frame
//   rd_en        pop request for the FIFO head
//   err_clr      clears the sticky overflow flag
//   data         FIFO head byte, valid while rda=1 (0 when empty)
//   rda          FIFO not empty
//   count        bytes held in the FIFO
//   full         count == FIFO_DEPTH
//   overflow     sticky: a received byte was dropped because the FIFO was full
//   parity_err   single-cycle pulse, frame discarded for bad parity
//   frame_err    single-cycle pulse, frame discarded for bad stop bit/timeout
//
// Optional feature
//   PS2_RX_TIMEOUT_EN  when defined, a stalled frame is abandoned after
//                      TIMEOUT_CYC cycles without a falling edge, and
//                      frame_err is pulsed.
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    input  logic                              rx_en,
    input  logic                              rd_en,
    input  logic                              err_clr,
    output logic [7:0]                        data,
    output logic                              rda,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              full,
    output logic                              overflow,
    output logic                              parity_err,
    output logic                              frame_err
);

    localparam int             CW        = $clog2(FIFO_DEPTH + 1);
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0]     FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);

    // Elaboration-time guard against unsupported parameter values.
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ps2_rx_fifo: FIFO_DEPTH must be a power of 2 in 2..256");
    end
    if (FILT_LEN < 1 || FILT_LEN > 16) begin : g_bad_filt
        $error("ps2_rx_fifo: FILT_LEN must be in 1..16");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("ps2_rx_fifo: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [3:0]    filt_cnt;
    logic          sample_evt;

    state_t        state, state_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          par_bit, par_next;
    logic          push, perr_next, ferr_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop, drop;

    // Two-flop synchronisers. They reset to the idle-high bus level, so that
    // leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter. filt_cnt counts consecutive samples that disagree with
    // filt_clk. The filtered clock flips on the FILT_LEN-th such sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= 4'd0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= 4'd0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_s2;
            filt_cnt <= 4'd0;
        end else begin
            filt_cnt <= filt_cnt + 4'd1;
        end
    end

    // High in the cycle where filt_clk is about to fall. dat_s2 is sampled
    // in this same cycle.
    assign sample_evt = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;
    logic          timeout;

    // Counts cycles since the last sample event while a frame is open.
    always_ff @(posedge clk) begin
        if (!rst || state == IDLE || sample_evt) begin
            tmo_cnt <= '0;
        end else if (!timeout) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC));
`endif

    // Frame FSM state and shift registers. The error outputs are registered
    // copies of the single-cycle flags that the next-state logic produces.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            par_bit    <= par_next;
            parity_err <= perr_next;
            frame_err  <= ferr_next;
        end
    end

    // Next-state logic. rx_en=0 overrides everything. A sample event takes
    // priority over a timeout that expires in the same cycle.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        par_next     = par_bit;
        push         = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
        if (!rx_en) begin
            state_next = IDLE;
        end else if (sample_evt) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                DATA: begin
                    shift_next   = {dat_s2, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    par_next   = dat_s2;
                    state_next = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    perr_next  = ~(^{shift_reg, par_bit});
                    ferr_next  = ~dat_s2;
                    push       = (^{shift_reg, par_bit}) & dat_s2;
                end
                default: state_next = IDLE;
            endcase
        end
`ifdef PS2_RX_TIMEOUT_EN
        else if (timeout) begin
            state_next = IDLE;
            ferr_next  = 1'b1;
        end
`endif
    end

    assign rda     = (count != '0);
    assign full    = (count == DEPTH_C);
    assign data    = rda ? mem[rd_ptr] : 8'h00;
    assign do_pop  = rd_en && rda;
    // When the FIFO is full, a same-cycle pop frees the slot that the push
    // writes into.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Storage has no reset. data is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    // A new overflow takes priority over err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
//
// Self-checking bench for ps2_rx_fifo with default parameters. It uses a
// 10 ns clk and 150 ns PS/2 bit cells. The expected FIFO contents live in a
// byte queue. The sticky overflow flag and the error-pulse counts are derived
// from the frame rules. One process compares all outputs against the queue
// on every cycle in which they are stable. A few literal checks pin the
// model to known values. Define PS2_RX_TIMEOUT_EN to include the stall test.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TMO   = 20000;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          ps2_clk  = 1'b1;
    logic          ps2_data = 1'b1;
    logic          rx_en    = 1'b0;
    logic          rd_en    = 1'b0;
    logic          err_clr  = 1'b0;
    logic [7:0]    data;
    logic          rda;
    logic [CW-1:0] count;
    logic          full, overflow, parity_err, frame_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    bit         chk_en = 1'b0;
    bit         stop_fall_seen = 1'b0;
    int         perr_cnt = 0;
    int         ferr_cnt = 0;
    int         push_lat = 0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FILT_LEN   (FILT),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_en     (rx_en),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .data      (data),
        .rda       (rda),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] expected_outputs();
        logic [7:0] head;
        head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        return {15'd0, head, model_q.size() != 0, CW'(model_q.size()),
                model_q.size() == DEPTH, model_ovf, 2'b00};
    endfunction

    // Per-cycle compare and error-pulse counting.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (parity_err === 1'b1) perr_cnt++;
            if (frame_err === 1'b1) ferr_cnt++;
            if (chk_en) begin
                checkOutput("cycle_outputs",
                            {15'd0, data, rda, count, full, overflow, parity_err, frame_err},
                            expected_outputs());
            end
        end
    end

    // Sends the first nbits bits of a frame. When rd_at > 0, rd_en is pulsed
    // at the rd_at-th clk posedge after the stop-bit falling edge.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                 input int nbits, input int rd_at);
        logic [10:0] frame;
        logic        par;
        int          perr_base, ferr_base;
        bit          perr_exp, ferr_exp;
        par       = ~(^b) ^ bad_par;
        frame     = {~bad_stop, par, b, 1'b0};
        perr_base = perr_cnt;
        ferr_base = ferr_cnt;
        stop_fall_seen = 1'b0;
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            #40;
            if (i == 10) begin
                chk_en = 1'b0;
                stop_fall_seen = 1'b1;
            end
            ps2_clk = 1'b0;
            if (i == 10 && rd_at > 0) begin
                fork
                    begin
                        repeat (rd_at - 1) @(negedge clk);
                        rd_en = 1'b1;
                        @(posedge clk);
                        #1;
                        rd_en = 1'b0;
                        if (model_q.size() > 0) model_q.delete(0);
                    end
                    begin
                        #70;
                        ps2_clk = 1'b1;
                    end
                join
            end else begin
                #70;
                ps2_clk = 1'b1;
            end
            #40;
        end
        if (nbits == 11) begin
            repeat (6) @(posedge clk);
            #1;
            perr_exp = ~(^{b, par});
            ferr_exp = bad_stop;
            if (!perr_exp && !ferr_exp) begin
                if (model_q.size() < DEPTH) model_q.push_back(b);
                else model_ovf = 1'b1;
            end
            checkOutput("parity_err_pulses", perr_cnt - perr_base, {31'd0, perr_exp});
            checkOutput("frame_err_pulses", ferr_cnt - ferr_base, {31'd0, ferr_exp});
            chk_en = 1'b1;
        end
    endtask

    task automatic read_byte(output logic [7:0] got);
        @(negedge clk);
        got   = data;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        if (model_q.size() > 0) model_q.delete(0);
    endtask

    task automatic clear_overflow();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr   = 1'b0;
        model_ovf = 1'b0;
    endtask

    // Bounds the whole run.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] rb;
        bit         bp, bs;
        int         ra, nr;
        int         fbase;

        // Reset.
        rst   = 1'b0;
        rx_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        checkOutput("reset_count", count, 0);
        checkOutput("reset_rda", rda, 0);
        checkOutput("reset_data", data, 0);
        checkOutput("reset_full", full, 0);
        checkOutput("reset_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // First good frame. Also measures the push edge after the stop fall.
        fork
            applyStimulus(8'h53, 1'b0, 1'b0, 11, 0);
            begin
                wait (stop_fall_seen);
                for (int i = 1; i <= 20; i++) begin
                    @(posedge clk);
                    #3;
                    if (rda === 1'b1 && push_lat == 0) push_lat = i;
                end
            end
        join
        checkOutput("first_data", data, 8'h53);
        checkOutput("first_count", count, 1);
        checkOutput("first_rda", rda, 1);
        checkOutput("latency_in_bound", {31'd0, push_lat >= 1 && push_lat <= FILT + 3}, 1);
        if (push_lat == 0) push_lat = FILT + 2;
        read_byte(got);
        checkOutput("first_pop", got, 8'h53);
        checkOutput("empty_after_pop", rda, 0);

        // Bad parity: byte discarded.
        applyStimulus(8'h53, 1'b1, 1'b0, 11, 0);
        checkOutput("badpar_count", count, 0);
        checkOutput("badpar_rda", rda, 0);

        // Overflow with nine frames and no reads.
        for (int b = 1; b <= 9; b++) begin
            applyStimulus(8'(b), 1'b0, 1'b0, 11, 0);
            if (b == 8) checkOutput("full_after_8", full, 1);
        end
        checkOutput("overflow_set", overflow, 1);
        checkOutput("count_at_full", count, DEPTH);
        for (int k = 1; k <= 8; k++) begin
            read_byte(got);
            checkOutput("overflow_order", got, k);
        end
        clear_overflow();
        checkOutput("overflow_cleared", overflow, 0);

        // Full FIFO with a same-cycle pop and push.
        for (int b = 1; b <= 8; b++) applyStimulus(8'(b), 1'b0, 1'b0, 11, 0);
        applyStimulus(8'h09, 1'b0, 1'b0, 11, push_lat);
        checkOutput("popush_no_overflow", overflow, 0);
        checkOutput("popush_count", count, DEPTH);
        for (int k = 2; k <= 9; k++) begin
            read_byte(got);
            checkOutput("popush_order", got, k);
        end

        // Empty FIFO with a same-cycle pop request and push.
        applyStimulus(8'hA5, 1'b0, 1'b0, 11, push_lat);
        checkOutput("empty_popush_count", count, 1);
        read_byte(got);
        checkOutput("empty_popush_data", got, 8'hA5);

        // Stop-bit error alone, then both errors together.
        applyStimulus(8'h3C, 1'b0, 1'b1, 11, 0);
        applyStimulus(8'h3C, 1'b1, 1'b1, 11, 0);

        // Reset in the middle of a frame.
        applyStimulus(8'h11, 1'b0, 1'b0, 11, 0);
        applyStimulus(8'h22, 1'b0, 1'b0, 11, 0);
        applyStimulus(8'hFF, 1'b0, 1'b0, 5, 0);
        @(negedge clk);
        chk_en = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        chk_en    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(8'h53, 1'b0, 1'b0, 11, 0);
        checkOutput("after_reset_data", data, 8'h53);
        checkOutput("after_reset_count", count, 1);
        read_byte(got);

        // rx_en dropped in the middle of a frame. Reads still work.
        applyStimulus(8'h44, 1'b0, 1'b0, 11, 0);
        applyStimulus(8'hFF, 1'b0, 1'b0, 5, 0);
        @(negedge clk);
        rx_en = 1'b0;
        read_byte(got);
        checkOutput("read_while_disabled", got, 8'h44);
        repeat (3) @(negedge clk);
        rx_en = 1'b1;
        applyStimulus(8'h53, 1'b0, 1'b0, 11, 0);
        checkOutput("after_rxen_data", data, 8'h53);
        checkOutput("after_rxen_count", count, 1);
        read_byte(got);

`ifdef PS2_RX_TIMEOUT_EN
        // Stalled frame is abandoned after the timeout.
        applyStimulus(8'hFF, 1'b0, 1'b0, 5, 0);
        chk_en = 1'b0;
        fbase  = ferr_cnt;
        repeat (TMO - 20) @(posedge clk);
        #1;
        checkOutput("timeout_not_early", ferr_cnt - fbase, 0);
        repeat (FILT + 40) @(posedge clk);
        #1;
        checkOutput("timeout_frame_err", ferr_cnt - fbase, 1);
        chk_en = 1'b1;
        applyStimulus(8'h53, 1'b0, 1'b0, 11, 0);
        checkOutput("after_timeout_data", data, 8'h53);
        read_byte(got);
`endif

        // Random frames, reads and overflow clears.
        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 7) == 0);
            ra = ($urandom_range(0, 3) == 0) ? push_lat : 0;
            applyStimulus(rb, bp, bs, 11, ra);
            nr = $urandom_range(0, 2);
            for (int r = 0; r < nr; r++) read_byte(got);
            if ($urandom_range(0, 4) == 0) clear_overflow();
        end
        for (int k = 0; k <= DEPTH; k++) read_byte(got);
        checkOutput("drained_count", count, 0);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO depth in bytes (power of 2, 2..256).
REQ-002 The block SHALL have parameter FILT_LEN, default 4, meaning consecutive equal samples required before the filtered ps2_clk changes state (1..16).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 20000, meaning the clk-cycle limit between PS/2 falling edges inside a frame.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-006 The block SHALL have port ps2_clk, input, 1 bit, asynchronous PS/2 clock from the device.
REQ-007 The block SHALL have port ps2_data, input, 1 bit, asynchronous PS/2 data from the device.
REQ-008 The block SHALL have port rx_en, input, 1 bit, receive enable.
REQ-009 The block SHALL have port rd_en, input, 1 bit, pop request for the FIFO head.
REQ-010 The block SHALL have port err_clr, input, 1 bit, clears the sticky overflow flag.
REQ-011 The block SHALL have port data, output, 8 bits, FIFO head byte, valid while rda=1.
REQ-012 The block SHALL have port rda, output, 1 bit, FIFO not empty.
REQ-013 The block SHALL have port count, output, $clog2(FIFO_DEPTH+1) bits, bytes held in the FIFO.
REQ-014 The block SHALL have port full, output, 1 bit, count==FIFO_DEPTH.
REQ-015 The block SHALL have port overflow, output, 1 bit, sticky flag for a byte dropped while full.
REQ-016 The block SHALL have ports parity_err and frame_err, outputs, 1 bit each, single-cycle error pulses.

Function
REQ-017 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; filtered ps2_clk SHALL change only after FILT_LEN consecutive equal synchronised samples.
REQ-018 A sample event SHALL be a 1->0 transition of filtered ps2_clk; synchronised ps2_data SHALL be sampled in that cycle; edge-to-event latency SHALL be at most FILT_LEN+3 clk cycles.
REQ-019 The FSM SHALL have states IDLE, DATA, PARITY, STOP; IDLE->DATA on an event with data=0; an event with data=1 in IDLE SHALL be ignored.
REQ-020 In DATA, 8 events SHALL shift bits in LSB first, then go to PARITY; the PARITY event SHALL capture the parity bit and go to STOP.
REQ-021 On the STOP event the FSM SHALL return to IDLE; if stop=1 and odd parity holds (XOR of 8 data bits and parity = 1), the byte SHALL be pushed.
REQ-022 On bad parity the byte SHALL be discarded and parity_err pulsed; on stop=0 the byte SHALL be discarded and frame_err pulsed; if both occur, both SHALL pulse.
REQ-023 rx_en=0 SHALL force IDLE and silently abort any partial frame; FIFO reads SHALL remain functional.
REQ-024 FIFO SHALL be first-word-fall-through: rda SHALL assert the cycle after a push into an empty FIFO, with data valid that cycle.
REQ-025 rd_en=1 with rda=1 SHALL pop; the next head or rda=0 SHALL appear the following cycle; rd_en with rda=0 SHALL be ignored.
REQ-026 A push when full without a same-cycle pop SHALL drop the byte and set overflow; a push and pop in the same cycle when full SHALL both succeed without overflow.
REQ-027 A pop request and a push in the same cycle when empty SHALL ignore the pop and perform the push.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow.
REQ-029 overflow SHALL clear on err_clr=1 unless an overflow occurs in the same cycle, which SHALL take priority.

Reset
REQ-030 When rst=0 at a clk edge: FSM to IDLE, bit counter, pointers and count to 0, filter state to 1 (idle-high), and synchroniser flops to 1.
REQ-031 Reset values SHALL be: data=0, rda=0, count=0, full=0, overflow=0, parity_err=0, frame_err=0; a frame in progress SHALL be discarded with no error pulse.

Configuration
REQ-032 With macro PS2_RX_TIMEOUT_EN defined, a timeout counter SHALL run in DATA/PARITY/STOP and reset on every sample event.
REQ-033 When the counter reaches TIMEOUT_CYC, the FSM SHALL return to IDLE, discard the partial byte and pulse frame_err.
REQ-034 Without PS2_RX_TIMEOUT_EN, no timeout logic SHALL exist, and a stalled frame SHALL remain in its state until further events, rx_en=0, or reset.

Verification
REQ-035 Bench (clk 10 ns, ps2_clk 150 ns, defaults): frame start,0x53,parity=1,stop -> one push, rda=1, data=0x53, count=1, no error pulses.
REQ-036 Bench: frame with 0x53 and parity=0 -> parity_err pulses once, count unchanged, rda stays 0.
REQ-037 Bench: 9 valid frames 0x01..0x09 with no reads -> full=1 after 8; 0x09 dropped; overflow=1; pops yield 0x01..0x08; err_clr -> overflow=0.
REQ-038 Bench: full FIFO, rd_en held high for the whole 0x09 push cycle -> no overflow; final read order 0x02..0x09.
REQ-039 Bench with PS2_RX_TIMEOUT_EN: ps2_clk stops after 4 data bits -> frame_err after TIMEOUT_CYC cycles, FSM IDLE; next 0x53 frame received correctly.
REQ-040 Bench: rst=0 asserted mid-frame, and separately rx_en=0 mid-frame -> partial byte lost, no error pulse; next 0x53 frame received correctly.
